dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
- Serial DAC driver directly downstream of the sine-ROM sample source.
- Accepts one 8-bit sample per valid/ready handshake and serialises it as a 16-bit SPI mode-0 frame to an external DAC: CS_N low, MSB first, data launched on SCLK falling edges, sampled by the DAC on rising edges.
- Frame layout, MSB first: {CTRL_WORD[3:0], sample[7:0], 4'b0000}.
- Runs on the 50 MHz system clock. SCLK is derived internally by a divider.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range >= 1.
- GAP_CYC, 2: clk cycles CS_N is held high after a frame before in_ready reasserts; legal range >= 1.
- CTRL_WORD, 4'h0: fixed 4-bit control prefix sent ahead of the sample.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  sample to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample; high only in IDLE.
- dac_sclk  output  1  SPI clock; idles low.
- dac_cs_n  output  1  DAC chip select, active low.
- dac_sdi  output  1  serial data to the DAC.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse when CS_N rises at the end of a frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - dac_sclk=0, dac_cs_n=1, dac_sdi=0, frame_done=0, busy=0, in_ready=1.
  - Shift register and counters are cleared.
  - Reset applied mid-frame aborts the frame immediately. No partial completion and no frame_done pulse.
- All outputs are registered or decoded directly from the state register. No combinational path from in_valid to any output.
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE:
  - Acceptance occurs at the edge E0 where in_valid=1 and in_ready=1.
  - At E0: shift_reg <= {CTRL_WORD, in_data, 4'b0}; dac_cs_n <= 0; dac_sdi <= frame bit 15; bit_idx <= 15; div_cnt <= 0; state <= SETUP.
  - in_data is sampled only at E0. Later changes on in_data are ignored.
- SETUP:
  - Held for CLK_DIV cycles.
  - At E0+CLK_DIV: dac_sclk <= 1 (first rising edge); state <= SHIFT.
- SHIFT:
  - dac_sclk toggles every CLK_DIV cycles.
  - Rising edges occur at E0+CLK_DIV+2*CLK_DIV*i, i=0..15.
  - On each falling toggle with bit_idx>0: dac_sdi <= next lower bit; bit_idx decrements.
  - On the falling toggle with bit_idx==0 (edge E0+32*CLK_DIV):
    - dac_sclk <= 0, dac_cs_n <= 1, dac_sdi <= 0;
    - frame_done <= 1 for exactly one cycle;
    - state <= GAP.
- GAP:
  - Counts GAP_CYC cycles, then state <= IDLE.
  - in_ready reasserts at edge E0+32*CLK_DIV+GAP_CYC.
- Timing:
  - Minimum frame period is 32*CLK_DIV+GAP_CYC clk cycles (66 at defaults).
  - SCLK frequency is 50 MHz/(2*CLK_DIV) (12.5 MHz at defaults).
- Exactly 16 SCLK rising edges occur per frame. dac_sdi is stable for CLK_DIV cycles before and after each rising edge.
- in_valid while not ready: ignored. Not queued, no side effects. The upstream source must hold or drop the sample.
- Back-to-back: if in_valid is high at the edge where in_ready first reasserts, the next frame starts at that edge. No extra idle cycle.
- Counter widths: div_cnt is sized to hold CLK_DIV-1; gap counter is sized to hold GAP_CYC-1. No wrap-around is permitted in either.

Test Plan:
- Reset values: assert rst=0 mid-SHIFT (bit_idx=7) -> same cycle: dac_cs_n=1, dac_sclk=0, dac_sdi=0, busy=0, in_ready=1; no frame_done pulse.
- Single frame, defaults: in_data=8'hA5 accepted at E0 -> bits 0000_1010_0101_0000 captured on 16 SCLK rises; dac_cs_n low for 64 cycles; frame_done at E0+64; in_ready at E0+66.
- Back-to-back: in_valid held high with 8'h00 then 8'hFF -> second CS_N falling edge at exactly E0+66; second frame shifts 0000_1111_1111_0000.
- Ignored input: in_valid pulsed with 8'h3C during SHIFT, in_data toggled after E0 -> frame contents unchanged; no extra frame.
- Parameter sweep: CLK_DIV=1, GAP_CYC=1, CTRL_WORD=4'h9, in_data=8'h81 -> SCLK at 25 MHz; frame 1001_1000_0001_0000; frame period 33 cycles.
- Protocol checker throughout: dac_sdi changes only while dac_sclk=0 or dac_cs_n=1; dac_sclk=0 whenever dac_cs_n=1; exactly 16 rising edges per frame.

Source files
------------

// File: rtl/dac_spi_tx.sv
// Serial DAC driver: takes one 8-bit sample per valid/ready handshake and shifts it out
// as a 16-bit SPI mode-0 frame {CTRL_WORD, sample, 4'b0000}, MSB first.
module dac_spi_tx #(
    parameter int          CLK_DIV   = 2,
    parameter int          GAP_CYC   = 2,
    parameter logic [3:0]  CTRL_WORD = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       dac_sclk,
    output logic       dac_cs_n,
    output logic       dac_sdi,
    output logic       busy,
    output logic       frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // The IDLE cycle is the last of the GAP_CYC high cycles, so GAP itself lasts GAP_CYC-1.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      shift_reg;
    logic [3:0]       bit_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept;
    logic             div_tick;
    logic             last_fall;

    assign accept    = (state == IDLE) && in_valid;
    assign div_tick  = (div_cnt == DIV_LAST);
    assign last_fall = (state == SHIFT) && div_tick && dac_sclk && (bit_idx == 4'd0);

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid)  state_nxt = SETUP;
            SETUP: if (div_tick)  state_nxt = SHIFT;
            SHIFT: if (last_fall) state_nxt = (GAP_CYC > 1) ? GAP : IDLE;
            GAP:   if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            dac_sclk   <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_sdi    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Bit 15 goes straight to the pin; the register holds bits 14..0 left-aligned.
                        shift_reg <= {CTRL_WORD[2:0], in_data, 5'b00000};
                        dac_sdi   <= CTRL_WORD[3];
                        dac_cs_n  <= 1'b0;
                        bit_idx   <= 4'd15;
                        div_cnt   <= '0;
                    end
                end
                SETUP: begin
                    if (div_tick) begin
                        div_cnt  <= '0;
                        dac_sclk <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else begin
                            dac_sclk <= 1'b0;
                            if (bit_idx != 4'd0) begin
                                dac_sdi   <= shift_reg[15];
                                shift_reg <= {shift_reg[14:0], 1'b0};
                                bit_idx   <= bit_idx - 4'd1;
                            end else begin
                                dac_cs_n   <= 1'b1;
                                dac_sdi    <= 1'b0;
                                frame_done <= 1'b1;
                                gap_cnt    <= '0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a default instance and a fast-divider instance, a bus monitor that
// records whole SPI frames, and per-scenario tasks comparing them to a frame-level model.
module tb_dac_spi_tx;

    typedef struct packed {
        int         e0;
        logic [7:0] data;
    } acc_t;

    typedef struct packed {
        int          cs_fall;
        int          cs_rise;
        int          first_rise;
        int          rises;
        logic [15:0] bits;
        logic        done;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data_a  [2];
    logic       in_valid_a [2];
    logic       in_ready_a [2];
    logic       sclk_a     [2];
    logic       cs_a       [2];
    logic       sdi_a      [2];
    logic       busy_a     [2];
    logic       done_a     [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    acc_t acc_q0 [$];
    acc_t acc_q1 [$];
    obs_t obs_q0 [$];
    obs_t obs_q1 [$];

    int          last_e0    [2];
    logic        p_sclk     [2];
    logic        p_cs       [2];
    logic        p_sdi      [2];
    bit          in_frame   [2];
    int          fall_cyc   [2];
    int          first_rise [2];
    int          rises      [2];
    logic [15:0] bits       [2];
    int          proto_err  [2];
    int          done_cnt   [2];
    int          exp_frames [2];

    always #10 clk = ~clk;

    dac_spi_tx u0 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data_a[0]),
        .in_valid   (in_valid_a[0]),
        .in_ready   (in_ready_a[0]),
        .dac_sclk   (sclk_a[0]),
        .dac_cs_n   (cs_a[0]),
        .dac_sdi    (sdi_a[0]),
        .busy       (busy_a[0]),
        .frame_done (done_a[0])
    );

    dac_spi_tx #(.CLK_DIV(1), .GAP_CYC(1), .CTRL_WORD(4'h9)) u1 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data_a[1]),
        .in_valid   (in_valid_a[1]),
        .in_ready   (in_ready_a[1]),
        .dac_sclk   (sclk_a[1]),
        .dac_cs_n   (cs_a[1]),
        .dac_sdi    (sdi_a[1]),
        .busy       (busy_a[1]),
        .frame_done (done_a[1])
    );

    // Reference: what the DAC should receive for a sample, straight from the frame layout.
    function automatic logic [15:0] model_frame(input int k, input logic [7:0] d);
        logic [3:0] ctrl;
        ctrl = (k == 0) ? 4'h0 : 4'h9;
        return {ctrl, d, 4'b0000};
    endfunction

    function automatic acc_t pop_acc(input int k);
        if (k == 0) return acc_q0.pop_front();
        return acc_q1.pop_front();
    endfunction

    function automatic obs_t pop_obs(input int k);
        if (k == 0) return obs_q0.pop_front();
        return obs_q1.pop_front();
    endfunction

    function automatic int obs_size(input int k);
        return (k == 0) ? obs_q0.size() : obs_q1.size();
    endfunction

    function automatic int acc_size(input int k);
        return (k == 0) ? acc_q0.size() : acc_q1.size();
    endfunction

    // Handshake recorder: sampled at the edge itself, before the DUT's state updates.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                if (in_valid_a[k] === 1'b1 && in_ready_a[k] === 1'b1) begin
                    if (k == 0) acc_q0.push_back('{e0: cyc + 1, data: in_data_a[k]});
                    else        acc_q1.push_back('{e0: cyc + 1, data: in_data_a[k]});
                    last_e0[k] = cyc + 1;
                end
            end
        end
    end

    // Bus monitor: rebuilds frames from SCLK rises and flags protocol violations.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst !== 1'b1) begin
                p_sclk[k]   = 1'b0;
                p_cs[k]     = 1'b1;
                p_sdi[k]    = 1'b0;
                in_frame[k] = 1'b0;
            end else begin
                if (sdi_a[k] !== p_sdi[k] && sclk_a[k] === 1'b1 && cs_a[k] === 1'b0) proto_err[k]++;
                if (sclk_a[k] === 1'b1 && cs_a[k] === 1'b1) proto_err[k]++;
                if (done_a[k] === 1'b1) done_cnt[k]++;
                if (p_cs[k] === 1'b1 && cs_a[k] === 1'b0) begin
                    in_frame[k]   = 1'b1;
                    fall_cyc[k]   = cyc;
                    first_rise[k] = -1;
                    rises[k]      = 0;
                    bits[k]       = '0;
                end
                if (p_sclk[k] === 1'b0 && sclk_a[k] === 1'b1 && cs_a[k] === 1'b0) begin
                    if (first_rise[k] < 0) first_rise[k] = cyc;
                    rises[k]++;
                    bits[k] = {bits[k][14:0], sdi_a[k]};
                end
                if (p_cs[k] === 1'b0 && cs_a[k] === 1'b1 && in_frame[k]) begin
                    if (k == 0) obs_q0.push_back('{fall_cyc[k], cyc, first_rise[k], rises[k], bits[k], done_a[k]});
                    else        obs_q1.push_back('{fall_cyc[k], cyc, first_rise[k], rises[k], bits[k], done_a[k]});
                    in_frame[k] = 1'b0;
                end
                p_sclk[k] = sclk_a[k];
                p_cs[k]   = cs_a[k];
                p_sdi[k]  = sdi_a[k];
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d, input bit keep);
        int n  = 0;
        bit ok = 1'b0;
        @(negedge clk);
        in_data_a[k]  = d;
        in_valid_a[k] = 1'b1;
        while (!ok && n < 300) begin
            @(posedge clk);
            ok = (in_ready_a[k] === 1'b1);
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL handshake inst%0d: got no accept want accept within 300 cycles", k);
        end
        if (!keep) begin
            @(negedge clk);
            in_valid_a[k] = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != target) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_cyc: got cycle %0d want %0d", cyc, target);
        end
    endtask

    task automatic wait_obs(input int k, input int cnt);
        int n = 0;
        while (obs_size(k) < cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (obs_size(k) < cnt) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_obs inst%0d: got %0d frames want %0d", k, obs_size(k), cnt);
        end
    endtask

    task automatic test_reset;
        int e0;
        int done_before;
        #5 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({cs_a[k], sclk_a[k], sdi_a[k], busy_a[k], in_ready_a[k], done_a[k]} !== 6'b100010) begin
                bad++;
                $display("[TB] FAIL reset_idle inst%0d: got %b want 100010", k,
                         {cs_a[k], sclk_a[k], sdi_a[k], busy_a[k], in_ready_a[k], done_a[k]});
            end
        end
        rst = 1'b1;
        send(0, 8'h5A, 1'b0);
        e0 = last_e0[0];
        wait_cyc(e0 + 33);
        total++;
        if ({cs_a[0], busy_a[0]} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL reset_midframe_pre: got cs/busy %b want 01", {cs_a[0], busy_a[0]});
        end
        done_before = done_cnt[0];
        rst = 1'b0;
        #1;
        total++;
        if ({cs_a[0], sclk_a[0], sdi_a[0], busy_a[0], in_ready_a[0], done_a[0]} !== 6'b100010) begin
            bad++;
            $display("[TB] FAIL reset_abort: got %b want 100010",
                     {cs_a[0], sclk_a[0], sdi_a[0], busy_a[0], in_ready_a[0], done_a[0]});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        total++;
        if (done_cnt[0] != done_before || obs_size(0) != 0) begin
            bad++;
            $display("[TB] FAIL reset_no_done: got done %0d frames %0d want done %0d frames 0",
                     done_cnt[0], obs_size(0), done_before);
        end
        acc_q0.delete();
    endtask

    task automatic test_single_frame;
        int   e0;
        acc_t a;
        obs_t o;
        send(0, 8'hA5, 1'b0);
        e0 = last_e0[0];
        wait_cyc(e0 + 64);
        total++;
        if ({done_a[0], cs_a[0], in_ready_a[0]} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL single_end: got done/cs/ready %b want 110", {done_a[0], cs_a[0], in_ready_a[0]});
        end
        wait_cyc(e0 + 65);
        total++;
        if ({done_a[0], in_ready_a[0], busy_a[0]} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL single_ready: got done/ready/busy %b want 010", {done_a[0], in_ready_a[0], busy_a[0]});
        end
        wait_obs(0, 1);
        if (obs_size(0) > 0 && acc_size(0) > 0) begin
            a = pop_acc(0);
            o = pop_obs(0);
            total++;
            if (o.bits !== 16'b0000_1010_0101_0000) begin
                bad++;
                $display("[TB] FAIL single_bits: got %b want 0000101001010000", o.bits);
            end
            total++;
            if (o.rises != 16 || o.cs_fall != a.e0 || o.cs_rise - o.cs_fall != 64 || o.first_rise != a.e0 + 2 || o.done !== 1'b1) begin
                bad++;
                $display("[TB] FAIL single_timing: got rises %0d fall %0d rise %0d first %0d done %b want 16 %0d %0d %0d 1",
                         o.rises, o.cs_fall, o.cs_rise, o.first_rise, o.done, a.e0, a.e0 + 64, a.e0 + 2);
            end
        end
        exp_frames[0]++;
    endtask

    task automatic test_back_to_back;
        acc_t a1, a2;
        obs_t o1, o2;
        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b0);
        wait_obs(0, 2);
        if (obs_size(0) >= 2 && acc_size(0) >= 2) begin
            a1 = pop_acc(0);
            a2 = pop_acc(0);
            o1 = pop_obs(0);
            o2 = pop_obs(0);
            total++;
            if (o2.cs_fall - o1.cs_fall != 66 || o2.cs_fall != a2.e0) begin
                bad++;
                $display("[TB] FAIL b2b_period: got %0d want 66", o2.cs_fall - o1.cs_fall);
            end
            total++;
            if (o1.bits !== model_frame(0, a1.data) || o2.bits !== 16'b0000_1111_1111_0000) begin
                bad++;
                $display("[TB] FAIL b2b_bits: got %h %h want %h 0ff0", o1.bits, o2.bits, model_frame(0, 8'h00));
            end
            total++;
            if (o2.rises != 16) begin
                bad++;
                $display("[TB] FAIL b2b_rises: got %0d want 16", o2.rises);
            end
        end
        exp_frames[0] += 2;
    endtask

    task automatic test_ignored_input;
        obs_t o;
        acc_t a;
        send(0, 8'h96, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_data_a[0]  = (i == 20) ? 8'h3C : 8'($urandom);
            in_valid_a[0] = (i == 20);
        end
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        wait_obs(0, 1);
        repeat (80) @(negedge clk);
        total++;
        if (acc_size(0) != 1 || obs_size(0) != 1) begin
            bad++;
            $display("[TB] FAIL ignored_count: got accepts %0d frames %0d want 1 1", acc_size(0), obs_size(0));
        end
        if (obs_size(0) > 0) begin
            o = pop_obs(0);
            total++;
            if (o.bits !== model_frame(0, 8'h96)) begin
                bad++;
                $display("[TB] FAIL ignored_bits: got %h want %h", o.bits, model_frame(0, 8'h96));
            end
        end
        while (acc_size(0) > 0) a = pop_acc(0);
        while (obs_size(0) > 0) o = pop_obs(0);
        exp_frames[0]++;
    endtask

    task automatic test_random;
        logic [7:0] dat [8];
        bit         kp  [8];
        acc_t       a;
        obs_t       o;
        int         prev_e0;
        bit         prev_kp;
        for (int i = 0; i < 8; i++) begin
            dat[i] = 8'($urandom);
            kp[i]  = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            send(0, dat[i], kp[i]);
            if (!kp[i]) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_obs(0, 8);
        prev_e0 = 0;
        prev_kp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (obs_size(0) > 0 && acc_size(0) > 0) begin
                a = pop_acc(0);
                o = pop_obs(0);
                total++;
                if (o.bits !== model_frame(0, dat[i]) || o.rises != 16) begin
                    bad++;
                    $display("[TB] FAIL random_frame%0d: got %h rises %0d want %h rises 16", i, o.bits, o.rises, model_frame(0, dat[i]));
                end
                total++;
                if (o.cs_fall != a.e0 || o.cs_rise != a.e0 + 64 || (prev_kp && a.e0 - prev_e0 != 66)) begin
                    bad++;
                    $display("[TB] FAIL random_timing%0d: got fall %0d rise %0d gap %0d want %0d %0d 66",
                             i, o.cs_fall, o.cs_rise, a.e0 - prev_e0, a.e0, a.e0 + 64);
                end
                prev_e0 = a.e0;
                prev_kp = kp[i];
            end
        end
        exp_frames[0] += 8;
    endtask

    task automatic test_param_sweep;
        logic [7:0] d2;
        obs_t       o1, o2;
        acc_t       a;
        d2 = 8'($urandom);
        send(1, 8'h81, 1'b1);
        send(1, d2, 1'b0);
        wait_obs(1, 2);
        if (obs_size(1) >= 2) begin
            o1 = pop_obs(1);
            o2 = pop_obs(1);
            total++;
            if (o1.bits !== 16'b1001_1000_0001_0000 || o2.bits !== model_frame(1, d2)) begin
                bad++;
                $display("[TB] FAIL sweep_bits: got %b %h want 1001100000010000 %h", o1.bits, o2.bits, model_frame(1, d2));
            end
            total++;
            if (o1.cs_rise - o1.cs_fall != 32 || o1.first_rise != o1.cs_fall + 1 || o1.rises != 16) begin
                bad++;
                $display("[TB] FAIL sweep_sclk: got len %0d first %0d rises %0d want 32 1 16",
                         o1.cs_rise - o1.cs_fall, o1.first_rise - o1.cs_fall, o1.rises);
            end
            total++;
            if (o2.cs_fall - o1.cs_fall != 33) begin
                bad++;
                $display("[TB] FAIL sweep_period: got %0d want 33", o2.cs_fall - o1.cs_fall);
            end
        end
        while (acc_size(1) > 0) a = pop_acc(1);
        exp_frames[1] += 2;
    endtask

    task automatic test_protocol;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (proto_err[k] != 0) begin
                bad++;
                $display("[TB] FAIL protocol inst%0d: got %0d violations want 0", k, proto_err[k]);
            end
            total++;
            if (done_cnt[k] != exp_frames[k]) begin
                bad++;
                $display("[TB] FAIL done_pulses inst%0d: got %0d want %0d", k, done_cnt[k], exp_frames[k]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_data_a[k]  = 8'h00;
            in_valid_a[k] = 1'b0;
            proto_err[k]  = 0;
            done_cnt[k]   = 0;
            exp_frames[k] = 0;
            last_e0[k]    = 0;
            in_frame[k]   = 1'b0;
        end
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_ignored_input;
        test_random;
        test_param_sweep;
        test_protocol;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
